// File: rtl/mcyc_data_mem_resp.sv
// Data-memory responder for the multicycle core: one request at a time,
// configurable wait states, single-cycle response with load data or error.
package mcyc_mem_pkg;
  typedef enum logic [2:0] {
    DT_B  = 3'd0,
    DT_H  = 3'd1,
    DT_W  = 3'd2,
    DT_BU = 3'd3,
    DT_HU = 3'd4
  } mem_dt_e;
endpackage

module mcyc_data_mem_resp
  import mcyc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  mem_dt_e     dt,
  output logic        busy,
  output logic        rdy,
  output logic        err,
  output logic [31:0] rdata
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_we_q, r_err_q;
  logic [AW+1:0]   r_addr_q;
  logic [31:0]     r_wdata_q;
  mem_dt_e         r_dt_q;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_bad, w_c_idle, w_c_ok, w_commit;
  logic [AW+1:0]   w_c_addr;
  logic [31:0]     w_c_data, w_wd, w_word, w_ld;
  mem_dt_e         w_c_dt;
  logic [3:0]      w_be;

  function automatic logic bad_req(mem_dt_e d, logic [31:0] a);
    logic mis;
    case (d)
      DT_B, DT_BU: mis = 1'b0;
      DT_H, DT_HU: mis = a[0];
      DT_W:        mis = |a[1:0];
      default:     mis = 1'b1;
    endcase
    return mis || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  assign w_bad = bad_req(dt, addr);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: if (req) begin
        if (w_bad || WAIT_CYCLES == 0) w_next = S_RESP;
        else begin
          w_next    = S_WAIT;
          w_cnt_nxt = CNT_INIT;
        end
      end
      S_WAIT: if (r_cnt == '0) w_next = S_RESP;
              else w_cnt_nxt = r_cnt - 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_err_q   <= 1'b0;
      r_we_q    <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_dt_q    <= DT_B;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && req) begin
        r_err_q   <= w_bad;
        r_we_q    <= we;
        r_addr_q  <= addr[AW+1:0];
        r_wdata_q <= wdata;
        r_dt_q    <= dt;
      end
    end
  end

  // With zero wait states RESP is entered straight from IDLE, so the commit
  // must take the live request; otherwise it uses the latched one.
  assign w_c_idle = (r_state == S_IDLE);
  assign w_c_addr = w_c_idle ? addr[AW+1:0] : r_addr_q;
  assign w_c_data = w_c_idle ? wdata : r_wdata_q;
  assign w_c_dt   = w_c_idle ? dt : r_dt_q;
  assign w_c_ok   = w_c_idle ? (req && we && !w_bad) : (r_we_q && !r_err_q);
  assign w_commit = w_c_ok && (w_next == S_RESP) && (r_state != S_RESP);

  always_comb begin
    w_be = '0;
    w_wd = w_c_data;
    case (w_c_dt)
      DT_B, DT_BU: begin
        w_be = 4'b0001 << w_c_addr[1:0];
        w_wd = {4{w_c_data[7:0]}};
      end
      DT_H, DT_HU: begin
        w_be = w_c_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_c_data[15:0]}};
      end
      DT_W:    w_be = 4'hF;
      default: w_be = '0;
    endcase
  end

  // Reset only blocks a write; storage contents survive reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && w_commit) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_c_addr[AW+1:2]][8*i +: 8] <= w_wd[8*i +: 8];
    end
  end

  assign w_word = r_mem[r_addr_q[AW+1:2]];

  always_comb begin
    w_ld = w_word;
    case (r_dt_q)
      DT_B:  w_ld = {{24{w_word[8*r_addr_q[1:0] + 7]}}, w_word[8*r_addr_q[1:0] +: 8]};
      DT_BU: w_ld = {24'h0, w_word[8*r_addr_q[1:0] +: 8]};
      DT_H:  w_ld = {{16{w_word[16*r_addr_q[1] + 15]}}, w_word[16*r_addr_q[1] +: 16]};
      DT_HU: w_ld = {16'h0, w_word[16*r_addr_q[1] +: 16]};
      default: w_ld = w_word;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign rdy   = (r_state == S_RESP);
  assign err   = rdy && r_err_q;
  assign rdata = (rdy && !r_we_q && !r_err_q) ? w_ld : 32'h0;
endmodule

// File: tb/tb_mcyc_data_mem_resp.sv
// Bench for mcyc_data_mem_resp: three instances (1, 0 and 3 wait states)
// checked against a byte-addressed reference memory.
module tb_mcyc_data_mem_resp;
  import mcyc_mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_s [NI];
  logic        we_s  [NI];
  logic [31:0] addr_s[NI];
  logic [31:0] wdata_s[NI];
  mem_dt_e     dt_s  [NI];
  logic        busy_s[NI];
  logic        rdy_s [NI];
  logic        err_s [NI];
  logic [31:0] rdata_s[NI];

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] last_rd;
  logic [7:0] mb [NI][4*DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mcyc_data_mem_resp #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk(clk), .rst(rst), .req(req_s[g]), .we(we_s[g]), .addr(addr_s[g]),
      .wdata(wdata_s[g]), .dt(dt_s[g]), .busy(busy_s[g]), .rdy(rdy_s[g]),
      .err(err_s[g]), .rdata(rdata_s[g])
    );
    logic r_prev = 1'b0;
    always @(negedge clk) begin
      if (rst && r_prev) begin
        chk($sformatf("k%0d rdy_single", g), 32'(rdy_s[g]), 32'h0);
        chk($sformatf("k%0d busy_after_rdy", g), 32'(busy_s[g]), 32'h0);
      end
      r_prev <= rdy_s[g];
    end
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic int dsize(input logic [2:0] t);
    case (t)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_err(input logic [2:0] t, input logic [31:0] a);
    int sz = dsize(t);
    if (sz == 0) return 1'b1;
    if ((a % 32'(sz)) != 0) return 1'b1;
    return a >= 32'(4*DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [31:0] a, input logic [2:0] t);
    logic [31:0] v = '0;
    for (int i = 0; i < dsize(t); i++) v[8*i +: 8] = mb[k][int'(a) + i];
    if (t == 3'd0) v = {{24{v[7]}}, v[7:0]};
    else if (t == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic scramble(input int k);
    addr_s[k]  = $urandom;
    wdata_s[k] = $urandom;
    we_s[k]    = 1'($urandom % 2);
    dt_s[k]    = mem_dt_e'(3'($urandom_range(0, 7)));
  endtask

  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] t, input bit poke);
    bit e, got;
    int lat;
    logic [31:0] er, o_rd;
    logic o_err, o_busy;
    e = model_err(t, a);
    er = '0; o_rd = '0; o_err = 1'b0; o_busy = 1'b0;
    if (!e && !w) er = model_load(k, a, t);
    if (!e && w) for (int i = 0; i < dsize(t); i++) mb[k][int'(a) + i] = d[8*i +: 8];
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; dt_s[k] = mem_dt_e'(t);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rdy_s[k]) begin
        got = 1'b1; o_rd = rdata_s[k]; o_err = err_s[k]; o_busy = busy_s[k];
      end
      scramble(k);
      req_s[k] = got & poke;
    end
    chk($sformatf("k%0d resp_seen", k), 32'(got), 32'h1);
    chk($sformatf("k%0d latency", k), 32'(lat), 32'(e ? 1 : 1 + wc(k)));
    chk($sformatf("k%0d err", k), 32'(o_err), 32'(e));
    chk($sformatf("k%0d rdata", k), o_rd, er);
    chk($sformatf("k%0d busy_in_resp", k), 32'(o_busy), 32'h1);
    last_rd = o_rd;
    @(negedge clk);
    chk($sformatf("k%0d rdy_drop", k), 32'(rdy_s[k]), 32'h0);
    chk($sformatf("k%0d idle_busy", k), 32'(busy_s[k]), 32'h0);
    chk($sformatf("k%0d idle_rdata", k), rdata_s[k], 32'h0);
    req_s[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ba[4];
    logic [2:0]  bt[4];
    logic [31:0] bexp[4];
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0; dt_s[k] = DT_W;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("k%0d rst_busy", k), 32'(busy_s[k]), 32'h0);
      chk($sformatf("k%0d rst_rdy", k), 32'(rdy_s[k]), 32'h0);
      chk($sformatf("k%0d rst_err", k), 32'(err_s[k]), 32'h0);
      chk($sformatf("k%0d rst_rdata", k), rdata_s[k], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // preload every word; word 0x30 holds zero
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++)
        txn(k, 1'b1, 32'(4*i), (i == 12) ? 32'h0 : $urandom, 3'd2, 1'b0);

    // word store/load, one wait state
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 3'd2, 1'b0);
    chk("plan_word", last_rd, 32'hDEADBEEF);

    // byte lanes and extension
    txn(0, 1'b1, 32'h20, 32'h11223344, 3'd2, 1'b0);
    txn(0, 1'b1, 32'h21, 32'h00000080, 3'd0, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 3'd2, 1'b0);
    chk("plan_merge", last_rd, 32'h11228044);
    txn(0, 1'b0, 32'h21, 32'h0, 3'd0, 1'b0);
    chk("plan_lb", last_rd, 32'hFFFFFF80);
    txn(0, 1'b0, 32'h21, 32'h0, 3'd3, 1'b0);
    chk("plan_lbu", last_rd, 32'h00000080);
    txn(0, 1'b0, 32'h22, 32'h0, 3'd1, 1'b0);
    chk("plan_lh", last_rd, 32'h00001122);

    // errors: misaligned, out of range, unknown type; req poked during RESP
    txn(0, 1'b0, 32'h22, 32'h0, 3'd2, 1'b1);
    txn(0, 1'b1, 32'(4*DEPTH), 32'h12345678, 3'd2, 1'b0);
    txn(0, 1'b1, 32'h0, 32'hA5A5A5A5, 3'd6, 1'b1);
    txn(0, 1'b0, 32'h0, 32'h0, 3'd2, 1'b0);

    // back-to-back loads with zero wait states, req held high
    for (int j = 0; j < 4; j++) begin
      bt[j] = 3'($urandom_range(0, 4));
      ba[j] = 32'($urandom_range(0, 4*DEPTH - 1)) & ~32'(dsize(bt[j]) - 1);
      bexp[j] = model_load(1, ba[j], bt[j]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b rdy%0d", i), 32'(rdy_s[1]), 32'(i % 2));
      chk($sformatf("b2b busy%0d", i), 32'(busy_s[1]), 32'(i % 2));
      if (i % 2 == 1) chk($sformatf("b2b rdata%0d", i), rdata_s[1], bexp[i/2]);
      if (i % 2 == 0) begin
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = ba[i/2]; dt_s[1] = mem_dt_e'(bt[i/2]);
      end
      if (i == 7) req_s[1] = 1'b0;
    end
    @(negedge clk);
    chk("b2b tail_rdy", 32'(rdy_s[1]), 32'h0);
    chk("b2b tail_busy", 32'(busy_s[1]), 32'h0);

    // reset aborts a store sitting in WAIT
    @(negedge clk);
    req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 32'h30; wdata_s[2] = 32'hCAFEF00D; dt_s[2] = DT_W;
    @(negedge clk);
    req_s[2] = 1'b0;
    chk("abort busy_wait", 32'(busy_s[2]), 32'h1);
    chk("abort no_rdy", 32'(rdy_s[2]), 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy_s[2]), 32'h0);
    chk("abort rdy", 32'(rdy_s[2]), 32'h0);
    chk("abort err", 32'(err_s[2]), 32'h0);
    chk("abort rdata", rdata_s[2], 32'h0);
    @(negedge clk);
    chk("abort held_rdy", 32'(rdy_s[2]), 32'h0);
    rst = 1'b1;
    txn(2, 1'b0, 32'h30, 32'h0, 3'd2, 1'b0);
    chk("abort old_value", last_rd, 32'h0);

    // randomized traffic on every instance
    for (int k = 0; k < NI; k++)
      for (int n = 0; n < 40; n++) begin
        logic [2:0] t;
        logic [31:0] a;
        t = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH - 1));
        if (dsize(t) != 0 && ($urandom % 2) == 1) a = a & ~32'(dsize(t) - 1);
        txn(k, 1'($urandom % 2), a, $urandom, t, 1'($urandom % 2));
      end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
